// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared definitions for the memory controller.
// Holds the FSM state encoding, load/store size encodings, the IO base
// address and the bytes-per-word constant, plus small decode helpers.
package cpu_defs;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFETCH = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_STORE  = 2'd3;

  // ls_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // UART / IO window base
  localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;

  // Index of the last byte of a transfer (n - 1); the illegal size 3 is treated as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_idx = 2'd0;
      SIZE_HALF: last_idx = 2'd1;
      default:   last_idx = 2'(BYTES_PER_WORD - 1);
    endcase
  endfunction

  // True when the address falls in the IO window (bits 17:16 match the IO base).
  function automatic logic is_io(input logic [ADDR_W-1:0] addr);
    is_io = (addr[17:16] == IO_BASE[17:16]);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller shared by instruction fetch and
// load/store. Words are moved one byte per cycle, little-endian.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state (mem_wr forced 0)
//   clear               flush; aborts an in-flight instruction fetch
//   if_req, if_addr     fetch request / byte address
//   instr_valid, instr  fetch completion pulse / fetched word
//   ls_req, ls_wr, ls_size, ls_addr, ls_wdata   data request
//   ls_done, ls_rdata   data completion pulse / zero-extended load data
//   mem_din, mem_dout, mem_a, mem_wr            byte-wide RAM port
//   io_buffer_full      blocks stores into the IO window
module mem_ctrl
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  logic [1:0]        state_q,  state_d;
  logic [1:0]        cnt_q,    cnt_d;
  logic [1:0]        last_q,   last_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [DATA_W-1:0] rbuf_q,   rbuf_d;
  logic              ivalid_q, ivalid_d;
  logic [DATA_W-1:0] instr_q,  instr_d;
  logic              done_q,   done_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [BYTE_W-1:0] dout_q,   dout_d;
  logic [ADDR_W-1:0] mema_q,   mema_d;
  logic              wr_q,     wr_d;

  logic [2:0]        k;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] rbuf_cap;
  logic              ls_block;
  logic              pulse_busy;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    ivalid_d = 1'b0;
    instr_d  = instr_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    dout_d   = dout_q;
    mema_d   = mema_q;
    wr_d     = wr_q;

    k         = 3'(cnt_q) + 3'd1;
    next_addr = addr_q + 32'(k);
    rbuf_cap  = rbuf_q;
    rbuf_cap[{cnt_q, 3'b000} +: BYTE_W] = mem_din;
    ls_block   = ls_wr && is_io(ls_addr) && io_buffer_full;
    // The cycle carrying a completion pulse is always spent in IDLE, so the
    // requester can drop or change its request before the next accept.
    pulse_busy = ivalid_q | done_q;

    case (state_q)
      ST_IDLE: begin
        mema_d = '0;
        dout_d = '0;
        wr_d   = 1'b0;
        cnt_d  = 2'd0;
        if (!pulse_busy) begin
          if (ls_req) begin
            // A blocked IO store also holds off the fetch for this cycle.
            if (!ls_block) begin
              addr_d = ls_addr;
              mema_d = ls_addr;
              last_d = last_idx(ls_size);
              rbuf_d = '0;
              if (ls_wr) begin
                state_d = ST_STORE;
                wdata_d = ls_wdata;
                dout_d  = ls_wdata[BYTE_W-1:0];
                wr_d    = 1'b1;
              end else begin
                state_d = ST_LOAD;
              end
            end
          end else if (if_req && !clear) begin
            state_d = ST_IFETCH;
            addr_d  = if_addr;
            mema_d  = if_addr;
            last_d  = 2'(BYTES_PER_WORD - 1);
            rbuf_d  = '0;
          end
        end
      end

      ST_IFETCH, ST_LOAD: begin
        if (state_q == ST_IFETCH && clear) begin
          state_d = ST_IDLE;
          mema_d  = '0;
          cnt_d   = 2'd0;
        end else begin
          rbuf_d = rbuf_cap;
          if (cnt_q == last_q) begin
            state_d = ST_IDLE;
            mema_d  = '0;
            cnt_d   = 2'd0;
            if (state_q == ST_IFETCH) begin
              instr_d  = rbuf_cap;
              ivalid_d = 1'b1;
            end else begin
              rdata_d = rbuf_cap;
              done_d  = 1'b1;
            end
          end else begin
            mema_d = next_addr;
            cnt_d  = cnt_q + 2'd1;
          end
        end
      end

      ST_STORE: begin
        if (cnt_q == last_q) begin
          state_d = ST_IDLE;
          mema_d  = '0;
          dout_d  = '0;
          wr_d    = 1'b0;
          cnt_d   = 2'd0;
          done_d  = 1'b1;
        end else begin
          mema_d = next_addr;
          dout_d = wdata_q[{k[1:0], 3'b000} +: BYTE_W];
          wr_d   = 1'b1;
          cnt_d  = cnt_q + 2'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        mema_d  = '0;
        dout_d  = '0;
        wr_d    = 1'b0;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State register; reset wins over rdy, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      last_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      ivalid_q <= 1'b0;
      instr_q  <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      dout_q   <= '0;
      mema_q   <= '0;
      wr_q     <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      ivalid_q <= ivalid_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      dout_q   <= dout_d;
      mema_q   <= mema_d;
      wr_q     <= wr_d;
    end
  end

  assign instr_valid = ivalid_q;
  assign instr       = instr_q;
  assign ls_done     = done_q;
  assign ls_rdata    = rdata_q;
  assign mem_dout    = dout_q;
  assign mem_a       = mema_q;
  // The RAM shares rdy, so a frozen cycle must never strobe a write.
  assign mem_wr      = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed, table-driven bench for mem_ctrl with a byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic        ls_req, ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int total = 0;
  int bad   = 0;

  // RAM model: combinational read, write on rising edge when mem_wr
  logic [7:0]  ram [0:32767];
  logic        pl_en = 1'b0;
  logic [31:0] pl_a  = '0;
  logic [7:0]  pl_d  = '0;
  int          wr_cnt = 0;

  function automatic int unsigned idx(input logic [31:0] a);
    return {17'd0, a[17:16], a[12:0]};
  endfunction

  assign mem_din = ram[idx(mem_a)];

  always @(posedge clk) begin
    if (pl_en) begin
      ram[idx(pl_a)] <= pl_d;
    end else if (mem_wr) begin
      ram[idx(mem_a)] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_req(if_req), .if_addr(if_addr),
    .instr_valid(instr_valid), .instr(instr),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          lat;
    int          wrs;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int lat;
    int base;
    bit done;
    lat  = 0;
    done = 0;
    base = wr_cnt;
    ls_req   = 1'b1;
    ls_wr    = v.wr;
    ls_size  = v.size;
    ls_addr  = v.addr;
    ls_wdata = v.wdata;
    tick();
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      lat++;
      if (ls_done) done = 1;
    end
    chk($sformatf("vec%0d_latency", n), 32'(lat), 32'(v.lat));
    if (!v.wr) chk($sformatf("vec%0d_rdata", n), ls_rdata, v.exp_rdata);
    ls_req = 1'b0;
    tick();
    chk($sformatf("vec%0d_writes", n), 32'(wr_cnt - base), 32'(v.wrs));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;

    vecs[0] = '{1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344, 32'h0, 4, 4};
    vecs[1] = '{1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h1122_3344, 4, 0};
    vecs[2] = '{1'b0, 2'd1, 32'h0000_0202, 32'h0, 32'h0000_1122, 2, 0};
    vecs[3] = '{1'b0, 2'd0, 32'h0000_0203, 32'h0, 32'h0000_0011, 1, 0};
    vecs[4] = '{1'b1, 2'd0, 32'h0000_0201, 32'hFFFF_FFAB, 32'h0, 1, 1};
    vecs[5] = '{1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h1122_AB44, 4, 0};
    vecs[6] = '{1'b1, 2'd1, 32'h0000_0300, 32'h1234_5678, 32'h0, 2, 2};
    vecs[7] = '{1'b0, 2'd1, 32'h0000_0300, 32'h0, 32'h0000_5678, 2, 0};

    // Preload RAM while reset is held
    poke(32'h0000_1000, 8'h13);
    poke(32'h0000_1001, 8'h05);
    poke(32'h0000_1002, 8'h00);
    poke(32'h0000_1003, 8'h00);
    poke(32'h0000_0020, 8'h5A);
    poke(32'hFFFF_FFFE, 8'h11);
    poke(32'hFFFF_FFFF, 8'h22);
    poke(32'h0000_0000, 8'h33);
    poke(32'h0000_0001, 8'h44);
    poke(32'h0000_0402, 8'h00);

    // Reset state
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_ls_done", 32'(ls_done), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Word fetch: byte addresses walk 1000..1003, valid 4 edges after accept
    if_req = 1'b1; if_addr = 32'h0000_1000;
    tick();
    chk("fetch_a0", mem_a, 32'h0000_1000);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("fetch_a%0d", i), mem_a, 32'h0000_1000 + 32'(i));
      chk($sformatf("fetch_novalid%0d", i), 32'(instr_valid), 32'h0);
    end
    tick();
    chk("fetch_valid", 32'(instr_valid), 32'h1);
    chk("fetch_instr", instr, 32'h0000_0513);
    chk("fetch_idle_a", mem_a, 32'h0);
    if_req = 1'b0;
    tick();
    chk("fetch_pulse_one", 32'(instr_valid), 32'h0);

    // Simultaneous load byte and fetch: load first, fetch after one IDLE cycle
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h0000_0020;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    tick();
    chk("prio_a", mem_a, 32'h0000_0020);
    tick();
    chk("prio_done", 32'(ls_done), 32'h1);
    chk("prio_rdata", ls_rdata, 32'h0000_005A);
    chk("prio_no_ivalid", 32'(instr_valid), 32'h0);
    ls_req = 1'b0;
    tick();
    chk("prio_idle_gap", mem_a, 32'h0);
    tick();
    chk("prio_fetch_a", mem_a, 32'h0000_1000);
    for (int i = 0; i < 4; i++) tick();
    chk("prio_fetch_valid", 32'(instr_valid), 32'h1);
    chk("prio_fetch_instr", instr, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    // Table of loads and stores
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Half store 0xBEEF to 0x104
    begin
      int base;
      base = wr_cnt;
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h0000_0104; ls_wdata = 32'h0000_BEEF;
      tick();
      chk("sh_wr0", 32'(mem_wr), 32'h1);
      chk("sh_a0", mem_a, 32'h0000_0104);
      chk("sh_d0", 32'(mem_dout), 32'h0000_00EF);
      tick();
      chk("sh_wr1", 32'(mem_wr), 32'h1);
      chk("sh_a1", mem_a, 32'h0000_0105);
      chk("sh_d1", 32'(mem_dout), 32'h0000_00BE);
      tick();
      chk("sh_done", 32'(ls_done), 32'h1);
      chk("sh_wr_off", 32'(mem_wr), 32'h0);
      ls_req = 1'b0;
      tick();
      chk("sh_count", 32'(wr_cnt - base), 32'd2);
      chk("sh_ram0", 32'(ram[idx(32'h0000_0104)]), 32'h0000_00EF);
      chk("sh_ram1", 32'(ram[idx(32'h0000_0105)]), 32'h0000_00BE);
    end

    // IO store blocked by io_buffer_full; fetch also held off
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("io_block_wr%0d", i), 32'(mem_wr), 32'h0);
      chk($sformatf("io_block_a%0d", i), mem_a, 32'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("io_go_wr", 32'(mem_wr), 32'h1);
    chk("io_go_a", mem_a, 32'h0003_0000);
    chk("io_go_d", 32'(mem_dout), 32'h0000_0041);
    tick();
    chk("io_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0; if_req = 1'b0;
    tick();
    chk("io_ram", 32'(ram[idx(32'h0003_0000)]), 32'h0000_0041);
    tick();

    // clear two cycles into a fetch
    if_req = 1'b1; if_addr = 32'h0000_1000;
    tick();
    tick();
    clear = 1'b1;
    tick();
    chk("clr_idle_a", mem_a, 32'h0);
    chk("clr_no_valid", 32'(instr_valid), 32'h0);
    clear = 1'b0;
    tick();
    chk("clr_refetch_a", mem_a, 32'h0000_1000);
    chk("clr_no_valid2", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("clr_refetch_valid", 32'(instr_valid), 32'h1);
    chk("clr_refetch_instr", instr, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    // rdy stall mid word-load across the 32-bit address wrap
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'hFFFF_FFFE;
    tick();
    chk("wrap_a0", mem_a, 32'hFFFF_FFFE);
    tick();
    chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
    tick();
    chk("wrap_a2", mem_a, 32'h0000_0000);
    rdy = 1'b0;
    tick();
    tick();
    chk("stall_a", mem_a, 32'h0000_0000);
    chk("stall_done", 32'(ls_done), 32'h0);
    rdy = 1'b1;
    tick();
    chk("wrap_a3", mem_a, 32'h0000_0001);
    chk("wrap_not_yet", 32'(ls_done), 32'h0);
    tick();
    chk("wrap_done", 32'(ls_done), 32'h1);
    chk("wrap_rdata", ls_rdata, 32'h4433_2211);
    ls_req = 1'b0;
    tick();

    // Reset in the middle of a word store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h0000_0400; ls_wdata = 32'hA1B2_C3D4;
    tick();
    tick();
    rst = 1'b1; ls_req = 1'b0;
    tick();
    chk("mrst_wr", 32'(mem_wr), 32'h0);
    chk("mrst_a", mem_a, 32'h0);
    chk("mrst_done", 32'(ls_done), 32'h0);
    chk("mrst_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("mrst_no_done", 32'(ls_done), 32'h0);
    chk("mrst_ram0", 32'(ram[idx(32'h0000_0400)]), 32'h0000_00D4);
    chk("mrst_ram1", 32'(ram[idx(32'h0000_0401)]), 32'h0000_00C3);
    chk("mrst_ram2", 32'(ram[idx(32'h0000_0402)]), 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: rdy  input  1  global enable; low freezes every register.
REQ-004 SHALL: clear  input  1  pipeline flush; aborts an in-flight instruction fetch.
REQ-005 SHALL: if_req  input  1  instruction fetch request, held until instr_valid.
REQ-006 SHALL: if_addr  input  32  fetch byte address, stable while if_req high.
REQ-007 SHALL: instr_valid  output  1  one-cycle pulse, instr valid.
REQ-008 SHALL: instr  output  32  fetched little-endian word.
REQ-009 SHALL: ls_req  input  1  data request, held until ls_done.
REQ-010 SHALL: ls_wr  input  1  1 = store, 0 = load.
REQ-011 SHALL: ls_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-012 SHALL: ls_addr  input  32  data byte address.
REQ-013 SHALL: ls_wdata  input  32  store data; low bytes used.
REQ-014 SHALL: ls_done  output  1  one-cycle completion pulse.
REQ-015 SHALL: ls_rdata  output  32  load data, zero-extended; sign extension happens downstream.
REQ-016 SHALL: mem_din  input  8  RAM read byte; valid one cycle after mem_a is driven.
REQ-017 SHALL: mem_dout  output  8  RAM write byte.
REQ-018 SHALL: mem_a  output  32  RAM byte address.
REQ-019 SHALL: mem_wr  output  1  RAM write strobe.
REQ-020 SHALL: io_buffer_full  input  1  UART buffer full; blocks stores to the IO range.

Function
REQ-021 SHALL: FSM states are IDLE, IFETCH, LOAD and STORE, with a byte counter cnt (0..3) and a byte total n = 1 << ls_size (4 for fetch).
REQ-022 SHALL: requests are sampled only in IDLE; ls_req has priority over if_req.
REQ-023 SHALL: at accept edge E0, the block latches the address and drives mem_a = addr, cnt = 0; for a store it also drives mem_wr = 1 and mem_dout = byte0.
REQ-024 SHALL: read (IFETCH/LOAD) at edge Ek, k = 1..n: capture mem_din into byte k-1; if k < n, drive mem_a = addr+k.
REQ-025 SHALL: at edge En of a read, pulse instr_valid/ls_done for one cycle with the assembled data and return to IDLE (word: valid 4 cycles after E0).
REQ-026 SHALL: store at edge Ek, k = 1..n-1: drive mem_a = addr+k and mem_dout = byte k with mem_wr = 1.
REQ-027 SHALL: at edge En of a store, mem_wr = 0, ls_done pulses and the FSM returns to IDLE.
REQ-028 SHALL: address arithmetic is 32-bit and wraps modulo 2^32 (e.g. 0xFFFFFFFF+1 = 0).
REQ-029 SHALL: a store with ls_addr[17:16] == 2'b11 while io_buffer_full = 1 is not accepted; the FSM stays in IDLE and if_req is not served that cycle.
REQ-030 SHALL: while clear = 1, IFETCH goes to IDLE at the next edge, instr_valid stays 0 and if_req is ignored that cycle.
REQ-031 SHALL: clear does not affect LOAD or STORE.
REQ-032 SHALL: while rdy = 0, all state and outputs hold, except mem_wr, which is forced to 0 (the RAM is frozen by the same rdy).
REQ-033 SHALL: in IDLE, mem_wr = 0, mem_a = 0 and mem_dout = 0; instr and ls_rdata hold their last value.
REQ-034 SHALL: after any completion there is at least one IDLE cycle; the requester deasserts req or changes the address in the cycle after the pulse.

Reset
REQ-035 SHALL: when rst = 1 at an edge (overrides rdy): state = IDLE, cnt = 0, instr_valid = 0, ls_done = 0, mem_wr = 0, mem_a = 0, mem_dout = 0, instr = 0, ls_rdata = 0.
REQ-036 SHALL: rst mid-operation abandons the transfer without a completion pulse; bytes already written remain in RAM.

Structure
REQ-037 SHALL: the shared package cpu_defs holds the FSM state encoding, the ls_size encodings, the IO base constant 0x30000 and the bytes-per-word constant.
REQ-038 SHALL: the block is a single flat module with no sub-module; byte assembly and address increment are inline.

Verification
REQ-039 SHALL: fetch 0x00001000 with RAM bytes 13 05 00 00 -> mem_a sequence 1000..1003, instr_valid pulse 4 cycles after accept, instr = 0x00000513.
REQ-040 SHALL: simultaneous ls_req (load byte at 0x20) and if_req -> load served first, ls_done with ls_rdata = 0x000000xx, then fetch starts after one IDLE cycle.
REQ-041 SHALL: store half 0xBEEF to 0x104 -> writes EF@0x104 and BE@0x105 with mem_wr = 1 for exactly 2 cycles, then ls_done.
REQ-042 SHALL: store byte to 0x30000 with io_buffer_full = 1 for 3 cycles -> no mem_wr during those cycles; the store proceeds the cycle after the flag drops.
REQ-043 SHALL: clear asserted 2 cycles into a fetch -> no instr_valid, FSM in IDLE, next fetch returns the correct word.
REQ-044 SHALL: rdy low for 2 cycles mid word-load at 0xFFFFFFFE -> result is delayed 2 cycles, mem_a wraps to 0x00000000 and 0x00000001, and the data is correct.
